// File: rtl/iter_shift_unit_if.sv
// Request/response bundle for the iterative shift engine.
// Handshake: start is honoured on a rising edge only when busy is low; done is a
// one-cycle pulse and result stays valid until the next accepted request completes.
interface iter_shift_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [2:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, op, data_in, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, op, data_in, shamt,
        output busy, done, result
    );
endinterface

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate engine: consumes up to three bit positions per cycle
// and pulses done with the final value; result is only written on entry to DONE.
module iter_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    iter_shift_unit_if.slave  bus,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_ROTL = 3'b011;
    localparam logic [2:0] OP_ROTR = 3'b100;

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   wr_q, wr_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               accept;
    logic               is_pass;
    logic [1:0]         step;
    logic [SHAMT_W-1:0] rem_next;
    logic [WIDTH-1:0]   wr_shifted;

    // Rotates go through a doubled copy so any step (including 0) needs no special case.
    function automatic logic [WIDTH-1:0] shift_by(input logic [2:0]       op_f,
                                                  input logic [WIDTH-1:0] val,
                                                  input logic [1:0]       amt);
        logic [2*WIDTH-1:0]       dbl;
        logic signed [WIDTH-1:0]  sra_v;
        logic [WIDTH-1:0]         res;
        dbl   = {val, val};
        sra_v = $signed(val) >>> amt;
        res   = val;
        case (op_f)
            OP_SLL:  res = val << amt;
            OP_SRL:  res = val >> amt;
            OP_SRA:  res = sra_v;
            OP_ROTL: begin
                dbl = dbl << amt;
                res = dbl[2*WIDTH-1 -: WIDTH];
            end
            OP_ROTR: begin
                dbl = dbl >> amt;
                res = dbl[WIDTH-1:0];
            end
            default: res = val;
        endcase
        return res;
    endfunction

    assign accept  = bus.start && (state_q != ST_SHIFT);
    assign is_pass = (bus.op > OP_ROTR);

    always_comb begin
        step = 2'd3;
        if (rem_q < SHAMT_W'(3)) begin
            step = rem_q[1:0];
        end
    end

    assign rem_next   = rem_q - SHAMT_W'(step);
    assign wr_shifted = shift_by(op_q, wr_q, step);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wr_d     = wr_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            ST_SHIFT: begin
                wr_d  = wr_shifted;
                rem_d = rem_next;
                if (rem_next == '0) begin
                    state_d  = ST_DONE;
                    result_d = wr_shifted;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A request accepted from IDLE or DONE overrides the default transition.
        if (accept) begin
            op_d  = bus.op;
            wr_d  = bus.data_in;
            rem_d = bus.shamt;
            if (bus.shamt == '0 || is_pass) begin
                state_d  = ST_DONE;
                result_d = bus.data_in;
            end else begin
                state_d = ST_SHIFT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            wr_q     <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            wr_q     <= wr_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign bus.busy    = (state_q == ST_SHIFT);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.result  = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: hand-computed results and latencies.
module tb_iter_shift_unit;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_tests;
    int         n_fail;

    iter_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    iter_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from idle; report cycles from the sampling edge to done.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] din,
                          input logic [4:0] sh, input logic [31:0] exp_res, input int exp_lat,
                          input int exp_busy);
        int lat;
        int busy_cycles;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.data_in = din;
        bus.shamt   = sh;
        tick();
        bus.start   = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cycles++;
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_cycles), 32'(exp_busy));
        check({tag, "_res"}, bus.result, exp_res);
        tick();
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_hold"}, bus.result, exp_res);
    endtask

    initial begin
        int seen_done;
        int lat;
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.data_in = 32'd0;
        bus.shamt   = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        run_op("sll5",   3'b000, 32'h0000_0001, 5'd5,  32'h0000_0020, 3,  2);
        run_op("sra31",  3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 12, 11);
        run_op("sra4",   3'b010, 32'h7000_0000, 5'd4,  32'h0700_0000, 3,  2);
        run_op("rotr4",  3'b100, 32'h1234_5678, 5'd4,  32'h8123_4567, 3,  2);
        run_op("rotl8",  3'b011, 32'h1234_5678, 5'd8,  32'h3456_7812, 4,  3);
        run_op("srl0",   3'b001, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  0);
        run_op("pass",   3'b111, 32'hCAFE_0000, 5'd9,  32'hCAFE_0000, 1,  0);
        run_op("rotl31", 3'b011, 32'h8000_0001, 5'd31, 32'hC000_0000, 12, 11);
        run_op("srl3",   3'b001, 32'hF000_0000, 5'd3,  32'h1E00_0000, 2,  1);

        // Ignored start while busy, then a request accepted in the done cycle.
        bus.start   = 1'b1;
        bus.op      = 3'b001;
        bus.data_in = 32'hFFFF_FFFF;
        bus.shamt   = 5'd9;
        tick();
        bus.op      = 3'b000;
        bus.data_in = 32'h0000_0000;
        bus.shamt   = 5'd3;
        tick();
        bus.start = 1'b0;
        lat = 2;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
        check("hs_lat", 32'(lat), 32'd4);
        check("hs_res1", bus.result, 32'h007F_FFFF);
        bus.start   = 1'b1;
        bus.op      = 3'b000;
        bus.data_in = 32'h0000_0001;
        bus.shamt   = 5'd1;
        tick();
        bus.start = 1'b0;
        check("hs_gap_done", 32'(bus.done), 32'd0);
        check("hs_gap_busy", 32'(bus.busy), 32'd1);
        check("hs_gap_hold", bus.result, 32'h007F_FFFF);
        tick();
        check("hs_done2", 32'(bus.done), 32'd1);
        check("hs_res2", bus.result, 32'h0000_0002);
        tick();

        // Abort an SLL by 31 with a two-cycle reset in the middle.
        bus.start   = 1'b1;
        bus.op      = 3'b000;
        bus.data_in = 32'h0000_0001;
        bus.shamt   = 5'd31;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("abort_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", bus.result, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.done || bus.busy) seen_done++;
            tick();
        end
        check("abort_quiet", 32'(seen_done), 32'd0);
        check("abort_result_hold", bus.result, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
Multi-cycle shift/rotate engine for the MIPS ALU. It complements the combinational 4-way shift-select stage. A request is latched on `start`, and the unit then shifts by at most 3 bit positions per cycle until the full shift amount is consumed. It then pulses `done` with the result. The ALU control uses it for variable shifts (SLLV/SRLV/SRAV) and rotates when a registered, low-area path is preferred over the full barrel shifter.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W <= WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe, sampled on rising clk edge.
- op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROTL, 100 ROTR, 101-111 pass-through.
- data_in  input  WIDTH  operand, latched when start is accepted.
- shamt  input  SHAMT_W  shift amount, latched when start is accepted.
- busy  output  1  high while the unit is in SHIFT.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- result  output  WIDTH  shifted/rotated value; holds until the next accepted start completes.

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, result=0.
  - Internal working register and remaining count are cleared.
  - Reset mid-operation aborts the shift with no done pulse.
- States:
  - IDLE, SHIFT, DONE.
  - busy = (state==SHIFT).
  - done = (state==DONE).
- Accepting a request:
  - start is accepted when state is IDLE or DONE.
  - On acceptance, latch op and data_in into the working register `wr`, and shamt into `rem`.
  - If rem==0 or op is pass-through, go to DONE; otherwise go to SHIFT.
  - start while in SHIFT is ignored; no queueing.
- SHIFT cycle:
  - step = min(rem,3); rem <= rem-step.
  - wr is updated by step positions:
    - SLL: zero-fill from the LSB side.
    - SRL: zero-fill from the MSB side.
    - SRA: fill with wr[WIDTH-1].
    - ROTL / ROTR: bits wrap around.
  - If rem-step==0, go to DONE with result <= updated wr; otherwise stay in SHIFT.
- DONE:
  - Lasts exactly one cycle, then goes to IDLE unless a new start is accepted in the same cycle.
  - Back-to-back requests give a done pulse every request with no idle bubble.
- Latency:
  - Count rising edges from the edge that samples start to the first cycle with done=1.
  - Latency = 1 + ceil(shamt/3). Examples: shamt=0 gives 1, shamt=3 gives 2, shamt=31 gives 12.
  - Pass-through latency = 1.
- Result:
  - Updated only on entry to DONE; stable in IDLE and SHIFT.
  - An aborted operation (reset) leaves result=0.
- Arithmetic and width:
  - Shifts are modulo WIDTH only via shamt width; no shamt >= WIDTH is possible.
  - SRA sign is preserved across every step because the fill always uses the current MSB.
- Simultaneous events:
  - rst wins over start.
  - start sampled in DONE is accepted while done is still high that cycle.

Test Plan:
- Reset/idle: assert rst for 2 cycles mid-SHIFT (SLL by 31 in progress).
  - Required: busy=0, done=0, result=0, and no done pulse afterwards.
- SLL shamt=5, data_in=0x0000_0001.
  - Required: busy high for 2 cycles, done on edge 3, result=0x0000_0020.
- SRA shamt=31, data_in=0x8000_0000.
  - Required: done at edge 12, result=0xFFFF_FFFF.
- SRA shamt=4, data_in=0x7000_0000.
  - Required: result=0x0700_0000.
- ROTR shamt=4, data_in=0x1234_5678.
  - Required: result=0x8123_4567.
- ROTL shamt=8, same data_in.
  - Required: result=0x3456_7812, latency 4.
- shamt=0 SRL, data_in=0xDEAD_BEEF.
  - Required: done at edge 1, result=0xDEAD_BEEF.
- op=111, data_in=0xCAFE_0000, shamt=9.
  - Required: done at edge 1, result=0xCAFE_0000.
- Handshake: assert start again while busy (SRL shamt=9), which must be ignored.
  - Then assert start in the done cycle (SLL shamt=1, data_in=0x1).
  - Required: two consecutive done pulses 2 edges apart; results 0x007F_FFFF (from data_in=0xFFFF_FFFF) then 0x0000_0002.
